// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Takes a count byte N, then 4*N data bytes (big-endian words). Each
// assembled word is written to instruction memory from word 0 upward.
// The CPU core stays in reset until the whole image is written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match before the core is released.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORDS  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;
`endif

  state_t              state_q;
  state_t              state_d;
  logic [7:0]          cnt_q;
  logic [1:0]          byte_q;
  logic [ADDR_W-1:0]   word_q;
  logic [23:0]         asm_q;
  logic                accept;
  logic                count_ok;
  logic                word_done;
  logic                last_word;
  logic [7:0]          word_ext;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  // Ready depends only on state, so acceptance never loops back into itself.
  assign rx_ready  = (state_q != S_RUN) && (state_q != S_ERR);
  assign accept    = rx_valid && rx_ready;
  assign count_ok  = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(WORDS));
  assign word_done = accept && (state_q == S_LOAD) && (byte_q == 2'd3);
  assign word_ext  = 8'(word_q);
  assign last_word = (word_ext + 8'd1) == cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: count check, end-of-image, optional checksum compare.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = count_ok ? S_LOAD : S_ERR;
      end
      S_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (word_done && last_word) state_d = S_CHECK;
`else
        if (word_done && last_word) state_d = S_RUN;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // Byte assembly, word counters and the registered memory-write stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      byte_q    <= 2'd0;
      word_q    <= '0;
      asm_q     <= 24'd0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= 32'd0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      im_we     <= word_done;
      cpu_rst_n <= (state_q == S_RUN);
      done      <= (state_q == S_RUN);
      err       <= (state_q == S_ERR);
      if (accept && (state_q == S_IDLE)) begin
        cnt_q  <= rx_data;
        byte_q <= 2'd0;
        word_q <= '0;
      end
      if (accept && (state_q == S_LOAD)) begin
        asm_q  <= {asm_q[15:0], rx_data};
        byte_q <= byte_q + 2'd1;
      end
      if (word_done) begin
        im_addr  <= word_q;
        im_wdata <= {asm_q, rx_data};
        word_q   <= word_q + ADDR_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of data bytes only; held clear while waiting for a count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           csum_q <= 8'd0;
    else if (state_q == S_IDLE)           csum_q <= 8'd0;
    else if (accept && state_q == S_LOAD) csum_q <= csum_q ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sequence with random data bytes,
// compared against an image-level model of the expected memory writes.
module tb_imem_loader;
  localparam int ADDR_W = 6;
  localparam int WORDS  = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .cpu_rst_n(cpu_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sent_cyc;

  logic [7:0]  img [0:255];
  int          obs_cyc[$];
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          exp_cyc[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  // Record every write strobe seen by the memory.
  always @(negedge clk) begin
    if (rst_n && im_we) begin
      obs_cyc.push_back(cyc);
      obs_addr.push_back(int'(im_addr));
      obs_data.push_back(im_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_rx_ready"},  32'(rx_ready),  32'd1);
    chk({pfx, "_im_we"},     32'(im_we),     32'd0);
    chk({pfx, "_im_addr"},   32'(im_addr),   32'd0);
    chk({pfx, "_im_wdata"},  im_wdata,       32'd0);
    chk({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({pfx, "_done"},      32'(done),      32'd0);
    chk({pfx, "_err"},       32'(err),       32'd0);
  endtask

  task automatic clear_q();
    obs_cyc.delete(); obs_addr.delete(); obs_data.delete();
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic do_reset(input string pfx);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset(pfx);
    clear_q();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    sent_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model: word i = bytes 4i..4i+3 big-endian at address i, visible the
  // cycle after its 4th byte is taken; core released one cycle after
  // the final write (or after the checksum byte).
  task automatic expect_byte(input int i);
    if (i % 4 == 3) begin
      exp_cyc.push_back(sent_cyc + 1);
      exp_addr.push_back(i / 4);
      exp_data.push_back({img[i-3], img[i-2], img[i-1], img[i]});
    end
  endtask

  task automatic load(input int n, input int gapmax, input bit good);
    logic [7:0] cs;
    cs = 8'd0;
    send(8'(n));
    for (int i = 0; i < 4 * n; i++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send(img[i]);
      cs ^= img[i];
      expect_byte(i);
    end
    rx_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("check_ready", 32'(rx_ready), 32'd1);
    send(good ? cs : (cs ^ 8'h01));
    rx_valid = 1'b0;
`endif
    chk("ready_after_load", 32'(rx_ready), 32'd0);
    chk("done_early", 32'(done), 32'd0);
    idle(1);
    chk("done", 32'(done), 32'(good));
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(good));
    chk("err_after_load", 32'(err), 32'(!good));
  endtask

  task automatic cmp_writes(input string pfx);
    int n;
    chk({pfx, "_wr_count"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({pfx, "_wr_addr"}, 32'(obs_addr[i]), 32'(exp_addr[i]));
      chk({pfx, "_wr_data"}, obs_data[i], exp_data[i]);
      chk({pfx, "_wr_cyc"},  32'(obs_cyc[i]), 32'(exp_cyc[i]));
    end
  endtask

  task automatic bad_count(input string pfx, input logic [7:0] n);
    do_reset({pfx, "_rst"});
    send(n);
    rx_valid = 1'b0;
    chk({pfx, "_err_early"}, 32'(err), 32'd0);
    chk({pfx, "_ready"}, 32'(rx_ready), 32'd0);
    idle(1);
    chk({pfx, "_err"}, 32'(err), 32'd1);
    chk({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) send(8'($urandom_range(1, 255)));
    idle(2);
    chk({pfx, "_err_sticky"}, 32'(err), 32'd1);
    cmp_writes(pfx);
  endtask

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    @(negedge clk);

    // Two-word image, back-to-back bytes.
    do_reset("reset");
    begin
      logic [7:0] pat [0:7];
      pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      for (int i = 0; i < 8; i++) img[i] = pat[i];
    end
    load(2, 0, 1'b1);
    idle(3);
    chk("run_ready", 32'(rx_ready), 32'd0);
    cmp_writes("two_word");
    if (obs_data.size() == 2) begin
      chk("word0_const", obs_data[0], 32'h12345678);
      chk("word1_const", obs_data[1], 32'h9ABCDEF0);
    end

    // Invalid counts.
    bad_count("count_zero", 8'h00);
    bad_count("count_over", 8'(WORDS + 1));

    // One word with random gaps, then bytes offered while running.
    do_reset("gap_rst");
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    load(1, 3, 1'b1);
    for (int i = 0; i < 3; i++) send(8'($urandom));
    chk("extra_ready", 32'(rx_ready), 32'd0);
    idle(2);
    cmp_writes("gap");
    chk("extra_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset("cs_rst");
    for (int i = 0; i < 4; i++) img[i] = 8'(i + 1);
    load(1, 0, 1'b1);
    cmp_writes("cs_good");
    do_reset("cs_rst2");
    load(1, 0, 1'b0);
    cmp_writes("cs_bad");
`endif

    // Reset in the middle of the second word.
    do_reset("mid_rst");
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    send(8'h02);
    for (int i = 0; i < 5; i++) begin
      send(img[i]);
      expect_byte(i);
    end
    rx_valid = 1'b0;
    cmp_writes("mid_partial");
    do_reset("mid_async");
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    load(1, 0, 1'b1);
    cmp_writes("mid_reload");

    // Full-size image.
    do_reset("full_rst");
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    load(WORDS, 0, 1'b1);
    cmp_writes("full");
    if (obs_addr.size() > 0)
      chk("full_last_addr", 32'(obs_addr[obs_addr.size()-1]), 32'(WORDS - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory. It accepts a byte stream (word count, then big-endian instruction words), assembles 32-bit words and drives instruction-memory write strobes starting at word 0. It holds the CPU core in reset until the image is fully written, then releases it.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width, matching the 6-bit word-indexed PC slice.
- `WORDS`, default 64: maximum image size in words; must be ≤ 2^ADDR_W and ≤ 255.
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rx_valid`  in  1: a byte is offered on `rx_data`.
- `rx_data`  in  8: offered byte.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `im_we`  out  1: instruction-memory write strobe, one-cycle pulse per word.
- `im_addr`  out  ADDR_W: word address for the write.
- `im_wdata`  out  32: word to write.
- `cpu_rst_n`  out  1: active-low reset to the CPU core.
- `done`  out  1: image loaded, CPU running.
- `err`  out  1: sticky load error.

## Operation
- Handshake: a byte transfers on any rising edge where `rx_valid & rx_ready`. `rx_valid` without `rx_ready` is ignored. No other flow control exists.
- `rx_ready` is decoded combinationally from the state: 1 in IDLE, LOAD and CHECK; 0 in RUN and ERR.
- States:
  - IDLE: waits for the count byte N. If 1 ≤ N ≤ WORDS: latch N, clear the byte and word counters, go to LOAD. Otherwise go to ERR.
  - LOAD: shifts bytes into a 32-bit assembly register. The first byte of each word lands in bits 31:24. On the 4th byte of a word:
    - next cycle `im_we=1`, `im_wdata` = assembled word, `im_addr` = word index (0..N-1);
    - the word index then increments;
    - after word N-1 is written, go to RUN, or to CHECK when checksum is enabled.
  - CHECK (only with checksum enabled): waits for one checksum byte. If it equals the running checksum, go to RUN; otherwise go to ERR.
  - RUN: `cpu_rst_n=1`, `done=1`. Stays here until `rst_n`.
  - ERR: `err=1`, `cpu_rst_n=0`. Stays here until `rst_n`.
- Word-index arithmetic is ADDR_W bits. It never wraps, because N ≤ WORDS.

## Timing
- Reset values: state IDLE, `rx_ready=1`, `im_we=0`, `im_addr=0`, `im_wdata=0`, `cpu_rst_n=0`, `done=0`, `err=0`; counters and checksum cleared.
- `im_we`, `im_addr`, `im_wdata`, `cpu_rst_n`, `done` and `err` are all registered.
- Write latency: `im_we` asserts exactly one cycle after the edge that accepts the 4th byte. `im_addr` and `im_wdata` are valid in the same cycle.
- Back-to-back bytes (one per cycle) are sustained with no stall. A write pulse may coincide with acceptance of the next word's first byte.
- Without checksum: `cpu_rst_n` and `done` rise on the edge after the last `im_we` cycle. So `cpu_rst_n` is 1 in the cycle following the final write pulse.
- With checksum: `cpu_rst_n`/`done` (or `err`) rise on the edge after the checksum byte is accepted.
- Invalid count: `err` rises on the edge after the count byte is accepted, with no `im_we` ever issued.
- Reset mid-operation: asynchronous return to reset values. A partially written image is not erased. The next count byte restarts loading at address 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - an 8-bit running checksum is the XOR of every data byte (not the count byte), cleared in IDLE;
  - a CHECK state follows the last word, and a mismatch goes to ERR.
- Not defined: there is no CHECK state. LOAD goes straight to RUN after the last write, and no checksum byte is expected.

## Test plan
- Count 0x02, then bytes 12 34 56 78 9A BC DE F0 back-to-back (checksum disabled):
  - `im_we` pulses at addr 0 with 0x12345678 and at addr 1 with 0x9ABCDEF0;
  - `cpu_rst_n`, `done` = 1 the cycle after the second pulse;
  - `rx_ready` = 0 thereafter.
- Count 0x00, then separately a count of WORDS+1:
  - `err` = 1 one cycle after acceptance;
  - no `im_we`;
  - `cpu_rst_n` stays 0;
  - further `rx_valid` is ignored.
- Count 0x01 with random idle gaps on `rx_valid`, then extra bytes in RUN: a single write of the correct word, and the extra bytes are not accepted and cause no writes.
- With `IMEM_LOADER_CHECKSUM_EN`, count 0x01, data 01 02 03 04:
  - checksum 0x04 → RUN;
  - repeated after reset with checksum 0x05 → `err=1`, `done=0`.
- Count 0x02, assert `rst_n` low after the 5th data byte:
  - all outputs return to reset values immediately;
  - a new count 0x01 plus 4 bytes writes addr 0.
- Count WORDS (64) with 256 data bytes: last write at addr 63, then RUN.
